uart_rx_ctrl: RTL and testbench

Sequencing controller for the UART receive datapath (start detector, SIPO, parity checker, stop-bit checker).
- Synchronises the serial line and times every bit from an internal baud counter.
- Samples each bit at mid-bit and issues one-cycle strobes: shift to the SIPO, parity_load to the parity checker, check_stop to the stop checker.
- Reports frame completion, parity error and framing error.
- Replaces the free-running, unclocked control in the receiver top level.

---
 rtl/uart_rx_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx_in, times each bit from a baud counter
// and issues mid-bit strobes to the SIPO, parity checker and stop checker.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_in,
    input  logic       en,
    output logic       rx_bit,
    output logic       shift,
    output logic       parity_load,
    output logic       check_stop,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic          rx_prev_q, rx_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          par_q, par_d;
    logic          perr_q, perr_d;
    logic          rx_bit_q, rx_bit_d;
    logic          shift_q, shift_d;
    logic          parity_load_q, parity_load_d;
    logic          check_stop_q, check_stop_d;
    logic          rx_done_q, rx_done_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic          sample;

    always_comb begin
        sync1_d       = rx_in;
        rx_s_d        = sync1_q;
        rx_prev_d     = rx_s_q;
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        bit_idx_d     = bit_idx_q;
        par_d         = par_q;
        perr_d        = perr_q;
        rx_bit_d      = rx_bit_q;
        shift_d       = 1'b0;
        parity_load_d = 1'b0;
        check_stop_d  = 1'b0;
        rx_done_d     = 1'b0;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;

        // The start bit is checked at its middle; every later bit one full period on.
        if (state_q == S_START) begin
            sample = (cnt_q == HALF_M1);
        end else begin
            sample = (cnt_q == FULL_M1);
        end

        case (state_q)
            S_IDLE: begin
                if (en && rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 4'd0;
                        par_d     = PARITY_ODD;
                        perr_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    rx_bit_d = rx_s_q;
                    shift_d  = 1'b1;
                    par_d    = par_q ^ rx_s_q;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    rx_bit_d      = rx_s_q;
                    parity_load_d = 1'b1;
                    perr_d        = par_q ^ rx_s_q;
                    state_d       = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    rx_bit_d     = rx_s_q;
                    check_stop_d = 1'b1;
                    parity_err_d = perr_q;
                    if (rx_s_q) begin
                        rx_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart bit timing on each state entry and after every sample point.
        if (state_d != state_q || sample || state_q == S_IDLE) begin
            cnt_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= 4'd0;
            par_q         <= 1'b0;
            perr_q        <= 1'b0;
            rx_bit_q      <= 1'b0;
            shift_q       <= 1'b0;
            parity_load_q <= 1'b0;
            check_stop_q  <= 1'b0;
            rx_done_q     <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            par_q         <= par_d;
            perr_q        <= perr_d;
            rx_bit_q      <= rx_bit_d;
            shift_q       <= shift_d;
            parity_load_q <= parity_load_d;
            check_stop_q  <= check_stop_d;
            rx_done_q     <= rx_done_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_bit      = rx_bit_q;
    assign shift       = shift_q;
    assign parity_load = parity_load_q;
    assign check_stop  = check_stop_q;
    assign bit_idx     = bit_idx_q;
    assign busy        = busy_q;
    assign rx_done     = rx_done_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: each driven frame queues its expected
// strobes with their cycle numbers; the monitor pops and compares them.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int HALF = CPB / 2;
    localparam int DB = 8;
    localparam bit PODD = 1'b0;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_in = 1'b1;
    logic       en = 1'b1;
    logic       rx_bit, shift, parity_load, check_stop;
    logic [3:0] bit_idx;
    logic       busy, rx_done, parity_err, frame_err;

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_in      (rx_in),
        .en         (en),
        .rx_bit     (rx_bit),
        .shift      (shift),
        .parity_load(parity_load),
        .check_stop (check_stop),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned t;
        logic [6:0]  f;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned busy_cnt = 0;
    exp_t        mon_e;
    logic [6:0]  mon_obs;

    task automatic chk(input string tag, input longint unsigned got,
                       input longint unsigned want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Strobe k appears n+3+HALF+(k+1)*CPB cycles after the line first falls at n.
    task automatic push_exp(input int unsigned n, input logic [7:0] d,
                            input logic pb, input logic sbit, input int cnt);
        exp_t e;
        logic perr;
        perr = PODD ^ (^d) ^ pb;
        for (int k = 0; k < DB + 2 && k < cnt; k++) begin
            e.t   = n + 3 + HALF + (k + 1) * CPB;
            e.idx = (k < DB - 1) ? 4'(k + 1) : 4'(DB - 1);
            if (k < DB) e.f = {3'b100, d[k], 3'b000};
            else if (k == DB) e.f = {3'b010, pb, 3'b000};
            else e.f = {3'b001, sbit, sbit, perr, ~sbit};
            sb.push_back(e);
        end
    endtask

    task automatic line(input logic v, input int k);
        rx_in = v;
        tick(k);
    endtask

    task automatic send(input logic [7:0] d, input logic pb,
                        input logic sbit, input bit track);
        if (track) push_exp(cyc, d, pb, sbit, DB + 2);
        line(1'b0, CPB);
        for (int k = 0; k < DB; k++) line(d[k], CPB);
        line(pb, CPB);
        line(sbit, CPB);
        line(1'b1, 2 * CPB);
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (rstn && (shift | parity_load | check_stop |
                     rx_done | parity_err | frame_err)) begin
            mon_obs = {shift, parity_load, check_stop, rx_bit,
                       rx_done, parity_err, frame_err};
            if (sb.size() == 0) begin
                chk("unexpected", mon_obs, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe", mon_obs, mon_e.f);
                chk("time", cyc, mon_e.t);
                chk("bit_idx", bit_idx, mon_e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned b0;
        logic [7:0]  d5;

        #2;
        chk("rst_out", {rx_bit, shift, parity_load, check_stop, bit_idx,
                        busy, rx_done, parity_err, frame_err}, 0);
        tick(3);
        rstn = 1'b1;
        tick(5);

        send(8'hA5, 1'b0, 1'b1, 1'b1);
        chk("t1_sb", sb.size(), 0);
        chk("t1_idle", busy, 0);

        n = cyc;
        rx_in = 1'b0;
        tick(3);
        chk("t2_busy_on", busy, 1);
        tick(1);
        rx_in = 1'b1;
        tick(6);
        chk("t2_busy_pre", busy, 1);
        tick(1);
        chk("t2_busy_off", busy, 0);
        chk("t2_cyc", cyc - n, 11);
        tick(20);

        send(8'h03, 1'b1, 1'b1, 1'b1);
        chk("t3_sb", sb.size(), 0);

        push_exp(cyc, 8'h00, 1'b0, 1'b0, DB + 2);
        line(1'b0, 12 * CPB);
        chk("t4_break", busy, 1);
        chk("t4_sb", sb.size(), 0);
        line(1'b1, 4);
        chk("t4_idle", busy, 0);
        tick(10);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        chk("t4_next_sb", sb.size(), 0);

        d5 = 8'hA5;
        push_exp(cyc, d5, 1'b0, 1'b1, 3);
        line(1'b0, CPB);
        for (int k = 0; k < 3; k++) line(d5[k], CPB);
        rx_in = d5[3];
        tick(8);
        rstn = 1'b0;
        #1;
        chk("t5_rst_out", {rx_bit, shift, parity_load, check_stop, bit_idx,
                           busy, rx_done, parity_err, frame_err}, 0);
        chk("t5_sb", sb.size(), 0);
        tick(3);
        rx_in = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick(5);
        send(8'hFF, 1'b0, 1'b1, 1'b1);
        chk("t5_next_sb", sb.size(), 0);

        en = 1'b0;
        b0 = busy_cnt;
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("t6_en0_busy", busy_cnt - b0, 0);
        en = 1'b1;
        tick(4);
        fork
            send(8'h3C, 1'b0, 1'b1, 1'b1);
            begin
                tick(20);
                en = 1'b0;
            end
        join
        chk("t6_sb", sb.size(), 0);
        chk("t6_idle", busy, 0);
        en = 1'b1;
        tick(10);

        chk("final_sb", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
